radix_digit_histogram: RTL and testbench
========================================

RADIX_DIGIT_HISTOGRAM -- requirements
Module: radix_digit_histogram

Interface
REQ-001 Parameter KEY_W, default 32, sets the key width in bits.
REQ-002 Parameter DIGIT_W, default 4, sets the radix digit width; there are NB = 2^DIGIT_W buckets.
REQ-003 Parameter CNT_W, default 16, sets the bucket counter and offset width.
REQ-004 ACLK  in  1  single clock; all logic is on the rising edge.
REQ-005 ARESET  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  one-cycle request to begin a pass; sampled only in IDLE.
REQ-007 pass_idx  in  clog2(KEY_W/DIGIT_W)  digit select; digit = key[pass_idx*DIGIT_W +: DIGIT_W]; latched on accepted start.
REQ-008 s_key_tdata  in  KEY_W  key stream from the memory-read stage.
REQ-009 s_key_tvalid / s_key_tready  in / out  1  key stream handshake.
REQ-010 s_key_tlast  in  1  marks the final key of the frame.
REQ-011 m_off_tdata  out  CNT_W  exclusive prefix offset for the current bucket, consumed by the scatter stage.
REQ-012 m_off_tvalid / m_off_tready  out / in  1  offset stream handshake.
REQ-013 m_off_tlast  out  1  high with bucket NB-1.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle pulse at the end of a pass.
REQ-016 overflow  out  1  sticky flag for bucket counter saturation.

Function
REQ-017 The FSM SHALL have the states IDLE, CLEAR, COUNT, SCAN, OUT, DONE.
REQ-018 IDLE: s_key_tready=0, m_off_tvalid=0; start=1 SHALL latch pass_idx, clear overflow and go to CLEAR; start is ignored in all other states.
REQ-019 CLEAR: all NB counters SHALL be zeroed in one cycle, then the FSM goes to COUNT.
REQ-020 COUNT: s_key_tready=1; each handshake SHALL increment count[digit] by 1; a handshake with s_key_tlast=1 is counted and the FSM goes to SCAN.
REQ-021 A counter at 2^CNT_W-1 SHALL hold its value on further increments and set overflow=1.
REQ-022 SCAN: the block SHALL take exactly NB cycles and compute one bucket per cycle; off[0]=0, off[i]=off[i-1]+count[i-1] modulo 2^CNT_W; then it goes to OUT.
REQ-023 Latency: if the tlast handshake occurs in cycle T, m_off_tvalid SHALL first be high in cycle T+NB+1.
REQ-024 OUT: the block SHALL emit off[0..NB-1] in ascending order, one per handshake; tdata and tlast stay stable while tvalid=1 and tready=0; tvalid is never withdrawn before the handshake.
REQ-025 The handshake on bucket NB-1 SHALL move the FSM to DONE; DONE asserts done=1 for exactly one cycle and then returns to IDLE.
REQ-026 There are no zero-length frames; a single-key frame (tlast on the first key) SHALL be valid.
REQ-027 s_key_tvalid outside COUNT SHALL NOT be accepted, and the keys are not consumed.

Reset
REQ-028 ARESET=1 SHALL force IDLE on the next edge from any state, including mid-COUNT and mid-OUT.
REQ-029 Reset values: s_key_tready=0, m_off_tvalid=0, m_off_tdata=0, m_off_tlast=0, busy=0, done=0, overflow=0, all counters and offsets 0.
REQ-030 The first pass after reset SHALL produce results independent of any aborted pass.

Verification
REQ-031 pass_idx=0, keys 0x0..0xF once each, last on 0xF -> offsets 0,1,2,...,15; tlast with 15; done pulses once.
REQ-032 pass_idx=1, five keys 0x000000A3 -> offsets 0 for buckets 0..10 and 5 for buckets 11..15; check first tvalid exactly NB+1 cycles after tlast.
REQ-033 m_off_tready random 50% toggling -> tdata stable under stall, no drop or duplicate, same 16 values as with tready held high.
REQ-034 65537 keys all with digit 0 -> count[0]=65535, overflow=1, offsets 1..15 = 65535; next start clears overflow.
REQ-035 ARESET for one cycle mid-COUNT after 3 keys -> next cycle busy=0, tready=0; a following 4-key frame of digit 2 yields off[3..15]=4.
REQ-036 start pulsed during COUNT and OUT -> ignored, pass_idx unchanged; tvalid driven in IDLE -> tready stays 0.

Source files
------------

// File: rtl/radix_digit_histogram_if.sv
// AXI-stream style channel shared by the key input and offset output.
// master drives data/valid/last, slave answers with ready.
interface radix_digit_histogram_if #(
  parameter int W = 32
);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         tlast;

  modport master (
    output tdata, tvalid, tlast,
    input  tready
  );

  modport slave (
    input  tdata, tvalid, tlast,
    output tready
  );
endinterface

// File: rtl/radix_digit_histogram.sv
// Radix-sort digit histogram: counts one digit of each key per frame,
// then streams the exclusive prefix offsets for every bucket.
module radix_digit_histogram #(
  parameter int KEY_W   = 32,
  parameter int DIGIT_W = 4,
  parameter int CNT_W   = 16,
  localparam int NB     = 1 << DIGIT_W,
  localparam int NP     = KEY_W / DIGIT_W,
  localparam int PW     = (NP > 1) ? $clog2(NP) : 1
) (
  input  logic          ACLK,
  input  logic          ARESET,
  input  logic          start,
  input  logic [PW-1:0] pass_idx,
  radix_digit_histogram_if.slave  s_key,
  radix_digit_histogram_if.master m_off,
  output logic          busy,
  output logic          done,
  output logic          overflow
);

  typedef enum logic [2:0] {
    IDLE, CLEAR, COUNT, SCAN, OUT, DONE
  } state_t;

  state_t             state;
  logic [PW-1:0]      pidx;
  logic [CNT_W-1:0]   cnt [NB];
  logic [CNT_W-1:0]   off [NB];
  logic [CNT_W-1:0]   acc;
  logic [DIGIT_W-1:0] idx;
  logic [DIGIT_W-1:0] idx_nxt;
  logic [DIGIT_W-1:0] digit;
  logic               key_hs;
  logic               off_hs;
  logic               idx_last;

  assign digit    = DIGIT_W'(s_key.tdata >> (pidx * DIGIT_W));
  assign key_hs   = s_key.tvalid & s_key.tready;
  assign off_hs   = m_off.tvalid & m_off.tready;
  assign idx_nxt  = idx + 1'b1;
  assign idx_last = (idx == DIGIT_W'(NB - 1));

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state        <= IDLE;
      pidx         <= '0;
      acc          <= '0;
      idx          <= '0;
      s_key.tready <= 1'b0;
      m_off.tvalid <= 1'b0;
      m_off.tdata  <= '0;
      m_off.tlast  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      overflow     <= 1'b0;
      for (int i = 0; i < NB; i++) begin
        cnt[i] <= '0;
        off[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            pidx     <= pass_idx;
            overflow <= 1'b0;
            busy     <= 1'b1;
            state    <= CLEAR;
          end
        end
        CLEAR: begin
          for (int i = 0; i < NB; i++)
            cnt[i] <= '0;
          s_key.tready <= 1'b1;
          state        <= COUNT;
        end
        COUNT: begin
          if (key_hs) begin
            // saturate instead of wrapping so a huge bucket stays maximal
            if (&cnt[digit])
              overflow <= 1'b1;
            else
              cnt[digit] <= cnt[digit] + 1'b1;
            if (s_key.tlast) begin
              s_key.tready <= 1'b0;
              acc          <= '0;
              idx          <= '0;
              state        <= SCAN;
            end
          end
        end
        SCAN: begin
          off[idx] <= acc;
          acc      <= acc + cnt[idx];
          idx      <= idx_nxt;
          if (idx_last) begin
            // off[0] is always zero, so the first beat needs no lookup
            m_off.tvalid <= 1'b1;
            m_off.tdata  <= '0;
            m_off.tlast  <= (NB == 1);
            state        <= OUT;
          end
        end
        OUT: begin
          if (off_hs) begin
            if (idx_last) begin
              m_off.tvalid <= 1'b0;
              m_off.tlast  <= 1'b0;
              done         <= 1'b1;
              state        <= DONE;
            end else begin
              m_off.tdata <= off[idx_nxt];
              m_off.tlast <= (idx_nxt == DIGIT_W'(NB - 1));
              idx         <= idx_nxt;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_radix_digit_histogram.sv
// Directed bench for radix_digit_histogram: offsets, latency,
// stalls, saturation, mid-frame reset and ignored start pulses.
module tb_radix_digit_histogram;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] pidx;
  logic       busy;
  logic       done;
  logic       ovf;

  always #5 clk = ~clk;

  radix_digit_histogram_if #(.W(32)) key_if ();
  radix_digit_histogram_if #(.W(16)) off_if ();

  radix_digit_histogram dut (
    .ACLK     (clk),
    .ARESET   (rst),
    .start    (start),
    .pass_idx (pidx),
    .s_key    (key_if),
    .m_off    (off_if),
    .busy     (busy),
    .done     (done),
    .overflow (ovf)
  );

  int          total = 0;
  int          bad   = 0;
  logic [15:0] got     [16];
  logic [15:0] exp_off [16];
  logic [15:0] lmask;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [2:0] p);
    pidx  = p;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic send_key(input logic [31:0] k,
                          input logic last);
    int n = 0;
    key_if.tvalid = 1'b1;
    key_if.tdata  = k;
    key_if.tlast  = last;
    while (!key_if.tready && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("key_ready_timeout", 0, 1);
    tick();
    key_if.tvalid = 1'b0;
    key_if.tlast  = 1'b0;
  endtask

  task automatic wait_valid();
    int cyc = 0;
    while (!off_if.tvalid && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("latency", cyc, 16);
  endtask

  task automatic collect(input bit rnd);
    int          i = 0;
    int          guard = 0;
    logic        stalled = 1'b0;
    logic [15:0] held = '0;
    lmask = '0;
    while (i < 16 && guard < 2000) begin
      off_if.tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stalled) begin
        chk("stall_valid", off_if.tvalid, 1);
        chk("stall_data", off_if.tdata, held);
      end
      stalled = 1'b0;
      if (off_if.tvalid) begin
        if (off_if.tready) begin
          got[i]   = off_if.tdata;
          lmask[i] = off_if.tlast;
          i++;
        end else begin
          stalled = 1'b1;
          held    = off_if.tdata;
        end
      end
      tick();
      guard++;
    end
    off_if.tready = 1'b0;
    if (i < 16) chk("collect_timeout", i, 16);
    chk("tlast_mask", lmask, 16'h8000);
    chk("done_pulse", done, 1);
    tick();
    chk("done_clear", done, 0);
    chk("busy_idle", busy, 0);
  endtask

  task automatic check_offs(input string tag);
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s_off%0d", tag, i), got[i], exp_off[i]);
  endtask

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    pidx          = '0;
    key_if.tvalid = 1'b0;
    key_if.tdata  = '0;
    key_if.tlast  = 1'b0;
    off_if.tready = 1'b0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_kready", key_if.tready, 0);
    chk("rst_ovalid", off_if.tvalid, 0);
    chk("rst_odata", off_if.tdata, 0);
    chk("rst_olast", off_if.tlast, 0);
    rst = 1'b0;
    tick();

    // keys offered while idle must not be taken
    key_if.tvalid = 1'b1;
    key_if.tdata  = 32'h5;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_kready", key_if.tready, 0);
    end
    chk("idle_busy", busy, 0);
    key_if.tvalid = 1'b0;

    // one key per bucket
    do_start(3'd0);
    for (int k = 0; k < 16; k++)
      send_key(32'(k), k == 15);
    wait_valid();
    collect(1'b0);
    for (int i = 0; i < 16; i++) exp_off[i] = 16'(i);
    check_offs("seq");

    // pass 1, five keys into bucket 10, with stray starts
    do_start(3'd1);
    send_key(32'h0000_00A3, 1'b0);
    send_key(32'h0000_00A3, 1'b0);
    pidx  = 3'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("count_busy", busy, 1);
    send_key(32'h0000_00A3, 1'b0);
    send_key(32'h0000_00A3, 1'b0);
    send_key(32'h0000_00A3, 1'b1);
    wait_valid();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("out_valid_hold", off_if.tvalid, 1);
    chk("out_busy", busy, 1);
    collect(1'b0);
    for (int i = 0; i < 16; i++)
      exp_off[i] = (i <= 10) ? 16'd0 : 16'd5;
    check_offs("p1");

    // random back-pressure on the offset stream
    do_start(3'd0);
    for (int k = 0; k < 16; k++)
      send_key(32'(k) | 32'hFFFF_FF00, k == 15);
    wait_valid();
    collect(1'b1);
    for (int i = 0; i < 16; i++) exp_off[i] = 16'(i);
    check_offs("stall");

    // saturate bucket 0
    do_start(3'd0);
    chk("ovf_start", ovf, 0);
    for (int j = 0; j < 65537; j++)
      send_key(32'(j) << 4, j == 65536);
    chk("ovf_set", ovf, 1);
    wait_valid();
    collect(1'b0);
    for (int i = 0; i < 16; i++)
      exp_off[i] = (i == 0) ? 16'd0 : 16'hFFFF;
    check_offs("sat");
    chk("ovf_sticky", ovf, 1);

    // abort mid-count, then a clean frame
    do_start(3'd0);
    chk("ovf_cleared", ovf, 0);
    for (int j = 0; j < 3; j++)
      send_key(32'h7, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_kready", key_if.tready, 0);
    tick();
    do_start(3'd0);
    for (int j = 0; j < 4; j++)
      send_key(32'h2, j == 3);
    wait_valid();
    collect(1'b0);
    for (int i = 0; i < 16; i++)
      exp_off[i] = (i <= 2) ? 16'd0 : 16'd4;
    check_offs("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
